// File: rtl/ultrasonic_echo_responder_if.sv
// Ultrasonic ranging bus between the ranging initiator (master) and the
// emulated sensor (slave).
//   trigger_in   : initiator -> sensor, asynchronous trigger pulse
//   echo_width   : initiator -> sensor, programmed echo width in cycles
//   echo_out     : sensor -> initiator, echo pulse
//   busy         : sensor status, measurement in progress
//   short_trig   : sensor status pulse, trigger rejected as too short
//   ignored_trig : sensor status pulse, trigger edge arrived while busy
//   echo_done    : sensor status pulse, measurement finished
interface ultrasonic_echo_responder_if;
  logic        trigger_in;
  logic [20:0] echo_width;
  logic        echo_out;
  logic        busy;
  logic        short_trig;
  logic        ignored_trig;
  logic        echo_done;

  modport master (
    output trigger_in, echo_width,
    input  echo_out, busy, short_trig, ignored_trig, echo_done
  );

  modport slave (
    input  trigger_in, echo_width,
    output echo_out, busy, short_trig, ignored_trig, echo_done
  );
endinterface

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style target emulator. Watches a synchronized trigger, and after a
// valid trigger waits a fixed acoustic delay, then drives an echo pulse whose
// width equals the programmed (saturated) echo_width. A holdoff follows every
// measurement.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : ultrasonic_echo_responder_if.slave (trigger/width in, echo/status out)
module ultrasonic_echo_responder #(
  parameter int CLK_MHZ       = 50,
  parameter int MIN_TRIG_US   = 10,
  parameter int ECHO_DELAY_US = 100,
  parameter int HOLDOFF_US    = 1000,
  parameter int MAX_ECHO_MS   = 30
) (
  input logic                          clk,
  input logic                          rst,
  ultrasonic_echo_responder_if.slave   bus
);

  localparam logic [20:0] MIN_C   = 21'(CLK_MHZ * MIN_TRIG_US);
  localparam logic [20:0] DELAY_C = 21'(CLK_MHZ * ECHO_DELAY_US);
  localparam logic [20:0] HOLD_C  = 21'(CLK_MHZ * HOLDOFF_US);
  localparam logic [20:0] MAX_C   = 21'(CLK_MHZ * MAX_ECHO_MS * 1000);

  typedef enum logic [2:0] {IDLE, TRIG_HIGH, DELAY, ECHO, HOLDOFF} state_t;

  state_t      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [20:0] width_q, width_d;
  logic        echo_q, echo_d;
  logic        short_q, short_d;
  logic        ignored_q, ignored_d;
  logic        done_q, done_d;
  logic        s1_q, trig_s_q, trig_d1_q;
  logic        rise;

  assign rise = trig_s_q & ~trig_d1_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    short_d   = 1'b0;
    done_d    = 1'b0;
    ignored_d = rise && (state_q inside {DELAY, ECHO, HOLDOFF});
    case (state_q)
      IDLE: begin
        // The edge cycle is itself the first synchronized high cycle, so the
        // count starts at 1: a trigger of exactly MIN_C high cycles passes.
        if (rise) begin
          state_d = TRIG_HIGH;
          cnt_d   = 21'd1;
        end
      end
      TRIG_HIGH: begin
        if (trig_s_q) begin
          if (cnt_q < MIN_C) cnt_d = cnt_q + 21'd1;
        end else if (cnt_q >= MIN_C) begin
          width_d = (bus.echo_width > MAX_C) ? MAX_C : bus.echo_width;
          cnt_d   = '0;
          state_d = DELAY;
        end else begin
          short_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DELAY: begin
        // Exit one count late so the registered echo rises DELAY_C+1 edges
        // after entry, and echo_out/echo_done land on the same edge as the
        // state change.
        if (cnt_q == DELAY_C) begin
          cnt_d = '0;
          if (width_q != '0) begin
            state_d = ECHO;
          end else begin
            done_d  = 1'b1;
            state_d = HOLDOFF;
          end
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      ECHO: begin
        if (cnt_q == width_q - 21'd1) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = HOLDOFF;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      HOLDOFF: begin
        if (cnt_q == HOLD_C - 21'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    echo_d = (state_d == ECHO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      width_q   <= '0;
      echo_q    <= 1'b0;
      short_q   <= 1'b0;
      ignored_q <= 1'b0;
      done_q    <= 1'b0;
      s1_q      <= 1'b0;
      trig_s_q  <= 1'b0;
      trig_d1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      echo_q    <= echo_d;
      short_q   <= short_d;
      ignored_q <= ignored_d;
      done_q    <= done_d;
      s1_q      <= bus.trigger_in;
      trig_s_q  <= s1_q;
      trig_d1_q <= trig_s_q;
    end
  end

  assign bus.echo_out     = echo_q;
  assign bus.busy         = !(state_q inside {IDLE, TRIG_HIGH});
  assign bus.short_trig   = short_q;
  assign bus.ignored_trig = ignored_q;
  assign bus.echo_done    = done_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Randomized, self-checking bench for ultrasonic_echo_responder at CLK_MHZ=1.
// A negedge monitor records event cycles; each test compares them with
// timings computed from the protocol rules.
module tb_ultrasonic_echo_responder;
  localparam int MIN_T = 10;
  localparam int DLY   = 100;
  localparam int HOLD  = 1000;
  localparam int MAXW  = 30000;
  // Falling sample E0 -> 2 synchronizer edges -> DLY+1 edges in delay.
  localparam int LAT   = 2 + DLY + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ultrasonic_echo_responder_if bus();

  ultrasonic_echo_responder #(.CLK_MHZ(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: cumulative event counts and last event cycles.
  int n_rise = 0, n_done = 0, n_short = 0, n_ign = 0, n_busy = 0;
  int rise_cyc = 0, fall_cyc = 0, done_cyc = 0, busyfall_cyc = 0;
  logic echo_prev = 1'b0, busy_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.echo_out && !echo_prev) begin rise_cyc = cyc; n_rise++; end
    if (!bus.echo_out && echo_prev) fall_cyc = cyc;
    if (!bus.busy && busy_prev) busyfall_cyc = cyc;
    if (bus.echo_done) begin done_cyc = cyc; n_done++; end
    if (bus.short_trig) n_short++;
    if (bus.ignored_trig) n_ign++;
    if (bus.busy) n_busy++;
    echo_prev = bus.echo_out;
    busy_prev = bus.busy;
  end

  function automatic int model_width(input int w);
    return (w > MAXW) ? MAXW : w;
  endfunction

  // Hold trigger_in for n sampling edges; c0 = cycle count at falling sample.
  task automatic pulse_trig(input int n, output int c0);
    @(posedge clk); #1 bus.trigger_in = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.trigger_in = 1'b0;
    @(posedge clk); #1 c0 = cyc;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.echo_out !== 1'b0) begin errors++; $display("FAIL reset_echo got %b want 0", bus.echo_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if ({bus.short_trig, bus.ignored_trig, bus.echo_done} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b want 000", {bus.short_trig, bus.ignored_trig, bus.echo_done}); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (n_short + n_ign + n_done !== 0) begin errors++; $display("FAIL reset_release_pulses got %0d want 0", n_short + n_ign + n_done); end
  endtask

  // Accepted measurement of width w with trigger length n; full timing check.
  task automatic run_accepted(input string nm, input int n, input int w);
    int c0, br, bd, wm;
    br = n_rise; bd = n_done; wm = model_width(w);
    bus.echo_width = 21'(w);
    pulse_trig(n, c0);
    repeat (LAT + wm + HOLD + 10) @(posedge clk);
    @(negedge clk);
    checks++; if (n_done - bd !== 1) begin errors++; $display("FAIL %s done_count got %0d want 1", nm, n_done - bd); end
    if (wm == 0) begin
      checks++; if (n_rise - br !== 0) begin errors++; $display("FAIL %s no_echo got %0d rises want 0", nm, n_rise - br); end
      checks++; if (done_cyc !== c0 + LAT) begin errors++; $display("FAIL %s done_time got %0d want %0d", nm, done_cyc - c0, LAT); end
    end else begin
      checks++; if (n_rise - br !== 1) begin errors++; $display("FAIL %s echo_count got %0d want 1", nm, n_rise - br); end
      checks++; if (rise_cyc !== c0 + LAT) begin errors++; $display("FAIL %s echo_rise got %0d want %0d", nm, rise_cyc - c0, LAT); end
      checks++; if (fall_cyc - rise_cyc !== wm) begin errors++; $display("FAIL %s echo_width got %0d want %0d", nm, fall_cyc - rise_cyc, wm); end
      checks++; if (done_cyc !== fall_cyc) begin errors++; $display("FAIL %s done_at_fall got %0d want %0d", nm, done_cyc, fall_cyc); end
    end
    checks++; if (busyfall_cyc - done_cyc !== HOLD) begin errors++; $display("FAIL %s holdoff got %0d want %0d", nm, busyfall_cyc - done_cyc, HOLD); end
  endtask

  task automatic run_short(input string nm, input int n);
    int c0, bs, br, bb;
    bs = n_short; br = n_rise; bb = n_busy;
    bus.echo_width = 21'd500;
    pulse_trig(n, c0);
    repeat (LAT + 20) @(posedge clk);
    @(negedge clk);
    checks++; if (n_short - bs !== 1) begin errors++; $display("FAIL %s short_count got %0d want 1", nm, n_short - bs); end
    checks++; if (n_rise - br !== 0) begin errors++; $display("FAIL %s echo_count got %0d want 0", nm, n_rise - br); end
    checks++; if (n_busy - bb !== 0) begin errors++; $display("FAIL %s busy_cycles got %0d want 0", nm, n_busy - bb); end
  endtask

  task automatic test_nominal;
    run_accepted("nominal", 12, 500);
  endtask

  task automatic test_trig_boundary;
    run_short("trig9", MIN_T - 1);
    run_accepted("trig10", MIN_T, 40);
  endtask

  task automatic test_saturation_zero;
    run_accepted("saturate", 12, 2000000);
    run_accepted("zero_width", 12, 0);
  endtask

  task automatic test_retrigger;
    int c0, c1, br, bi;
    br = n_rise; bi = n_ign;
    bus.echo_width = 21'd500;
    pulse_trig(12, c0);
    repeat (LAT + 100 - 1) @(posedge clk);
    pulse_trig(12, c1);
    repeat (500 + HOLD + 20) @(posedge clk);
    @(negedge clk);
    checks++; if (n_ign - bi !== 1) begin errors++; $display("FAIL retrig ignored got %0d want 1", n_ign - bi); end
    checks++; if (n_rise - br !== 1) begin errors++; $display("FAIL retrig echo_count got %0d want 1", n_rise - br); end
    checks++; if (fall_cyc - rise_cyc !== 500) begin errors++; $display("FAIL retrig echo_width got %0d want 500", fall_cyc - rise_cyc); end
  endtask

  task automatic test_latch;
    int c0;
    bus.echo_width = 21'd500;
    pulse_trig(12, c0);
    repeat (20) @(posedge clk);
    #1 bus.echo_width = 21'd50;
    repeat (LAT + 500 + HOLD) @(posedge clk);
    @(negedge clk);
    checks++; if (fall_cyc - rise_cyc !== 500) begin errors++; $display("FAIL latch echo_width got %0d want 500", fall_cyc - rise_cyc); end
  endtask

  task automatic test_reset_mid_echo;
    int c0, bd, bp;
    bus.echo_width = 21'd500;
    pulse_trig(12, c0);
    repeat (LAT + 200 - 1) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.echo_out !== 1'b1) begin errors++; $display("FAIL midecho_pre got %b want 1", bus.echo_out); end
    @(posedge clk); #3 rst = 1'b1;
    #1;
    checks++; if (bus.echo_out !== 1'b0) begin errors++; $display("FAIL midecho_async_drop got %b want 0", bus.echo_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midecho_busy got %b want 0", bus.busy); end
    bd = n_done; bp = n_short + n_ign;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (n_done - bd + n_short + n_ign - bp !== 0) begin
      errors++; $display("FAIL midecho_release_pulses got %0d want 0", n_done - bd + n_short + n_ign - bp); end
    run_accepted("after_reset", 12, 500);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      int n, w;
      n = $urandom_range(20, 1);
      w = (i == 0) ? 0 : $urandom_range(2000, 1);
      if (n >= MIN_T) run_accepted($sformatf("rand%0d", i), n, w);
      else            run_short($sformatf("rand%0d", i), n);
    end
  endtask

  initial begin
    bus.trigger_in = 1'b0;
    bus.echo_width = '0;
    test_reset;
    test_nominal;
    test_trig_boundary;
    test_saturation_zero;
    test_retrigger;
    test_latch;
    test_reset_mid_echo;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
